mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store front end sitting directly upstream of the word-addressed data memory (2048 × 32-bit, single-cycle registered read, `rd`/`wn` strobes).
- Accepts byte-addressed load/store requests from the execute stage over a valid/ready handshake.
- Checks alignment and range.
- Drives the memory strobes.
- Performs byte/halfword extraction with sign or zero extension.
- Implements sub-word stores as read-modify-write.
- Returns one response pulse per request.

## Interface
- `DEPTH_WORDS`, 2048: memory depth in 32-bit words; word index = `req_addr[31:2]`.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept; high only in IDLE.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 halfword, 10 word, 11 illegal.
- `req_signed` in 1: loads only; 1 = sign-extend, 0 = zero-extend.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `resp_valid` out 1: one-cycle response pulse; no backpressure.
- `resp_rdata` out 32: extended load data; 0 for stores and faults.
- `resp_fault` out 1: valid with `resp_valid`; misaligned, out-of-range or illegal size.
- `mem_rd` out 1: memory read strobe.
- `mem_wn` out 1: memory write strobe.
- `mem_address` out 32: word index to memory (`{2'b0, addr[31:2]}`).
- `mem_write_data` out 32: full word to memory.
- `mem_read_data` in 32: memory read data, valid the cycle after a `mem_rd` cycle.

## Operation
- States: IDLE, RD, CAP, WR, RESP. All outputs registered.
- IDLE:
  - A request is accepted when `req_valid && req_ready`; all request fields are latched on that edge.
  - Fault → RESP; load → RD; word store → WR; byte/half store → RD.
- RD: `mem_rd`=1, `mem_address` = word index → CAP.
- CAP: `mem_read_data` sampled at the end of the cycle.
  - Load: extract lane, extend, latch into the result → RESP.
  - Sub-word store: merge `req_wdata` into the sampled word at the addressed lane → WR.
- WR: `mem_wn`=1, `mem_write_data` = full or merged word → RESP.
- RESP: `resp_valid`=1 for exactly one cycle → IDLE.
- Lanes are little-endian: byte k = `addr[1:0]` occupies bits [8k+7:8k]; a halfword at `addr[1]`=h occupies bits [16h+15:16h].
- Fault conditions:
  - half with `addr[0]`=1;
  - word with `addr[1:0]`≠0;
  - `req_size`=11;
  - `addr[31:2]` ≥ `DEPTH_WORDS`.
- A faulting request:
  - makes no memory access;
  - returns `resp_rdata`=0 and `resp_fault`=1.
- `mem_rd` and `mem_wn` are never high in the same cycle; both are 0 outside RD/WR.
- `mem_address` and `mem_write_data` hold their last values while unused.

## Timing
- Reset values:
  - state IDLE, `req_ready`=1;
  - `resp_valid`=0, `resp_fault`=0, `resp_rdata`=0;
  - `mem_rd`=0, `mem_wn`=0, `mem_address`=0, `mem_write_data`=0.
- Latency is counted from the acceptance edge E0; `resp_valid` is high during the cycle after edge:
  - fault: E0 → RESP, so `resp_valid` in the cycle after E0 (1 cycle);
  - word store: E1 (2 cycles);
  - load: E2 (3 cycles);
  - sub-word store: E3 (4 cycles).
- `req_ready` is 0 from E0 until the edge leaving RESP; back-to-back requests therefore have a minimum spacing of latency+1 cycles.
- Requests presented while `req_ready`=0 are ignored, not queued.
- Reset asserted mid-operation:
  - The transaction is abandoned immediately and no `resp_valid` is produced.
  - Strobes drop asynchronously.
  - A write whose WR-cycle edge has not occurred is not performed.
- Sub-word stores are not atomic against other masters; this unit is the sole memory master.

## Test plan
- Word store then load:
  - SW addr 0x10, data 0xDEADBEEF → `mem_wn` pulse with `mem_address`=4, `resp_valid` 2 cycles after accept.
  - LW 0x10 → `resp_rdata`=0xDEADBEEF, `resp_valid` 3 cycles after accept.
- Byte/half loads on word 0x80C1F27F stored at 0x20:
  - LB 0x23 signed → 0xFFFFFF80;
  - LBU 0x20 → 0x0000007F;
  - LH 0x22 signed → 0xFFFF80C1;
  - LHU 0x20 → 0x0000F27F.
- Read-modify-write:
  - Word at 0x30 = 0x11223344; SB 0x31 data 0xAB → memory word 0x1122AB44 after 4 cycles.
  - Then SH 0x32 data 0xCDEF → 0xCDEFAB44.
- Faults:
  - LW 0x02, SH 0x05, size 11, LW 0x2000 → each `resp_fault`=1, `resp_rdata`=0, 1-cycle latency, `mem_rd`/`mem_wn` never asserted.
- Handshake:
  - `req_valid` held high across a load → exactly one memory access and one `resp_valid`.
  - `req_ready` low from acceptance until RESP exit; next request accepted on the edge after RESP.
- Reset mid-op: assert `rst` during CAP of an SB → no `mem_wn`, no `resp_valid`, memory word unchanged, outputs at reset values, `req_ready`=1 after release.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store front end for a word-addressed data memory: alignment/range checks,
// lane extraction with sign/zero extension, and read-modify-write for sub-word stores.
module mem_access_unit #(
    parameter int DEPTH_WORDS = 2048
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        mem_rd,
    output logic        mem_wn,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CAP  = 3'd2,
        S_WR   = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic        we_q;
    logic        signed_q;
    logic [1:0]  size_q;
    logic [1:0]  addr_lo_q;
    logic [15:0] wdata_q;

    logic        accept;
    logic        req_fault;
    logic [4:0]  lane_shift;
    logic [31:0] lane_data;
    logic [31:0] load_ext;
    logic [31:0] lane_mask;
    logic [31:0] merged_word;

    logic        req_ready_d;
    logic        resp_valid_d;
    logic [31:0] resp_rdata_d;
    logic        resp_fault_d;
    logic        mem_rd_d;
    logic        mem_wn_d;
    logic [31:0] mem_address_d;
    logic [31:0] mem_write_data_d;

    assign accept = req_valid && req_ready;

    always_comb begin
        req_fault = 1'b0;
        if (req_size == 2'b11)
            req_fault = 1'b1;
        if (req_size == 2'b01 && req_addr[0])
            req_fault = 1'b1;
        if (req_size == 2'b10 && req_addr[1:0] != 2'b00)
            req_fault = 1'b1;
        if ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS))
            req_fault = 1'b1;
    end

    // Lane position of the latched request; halfwords use only addr[1].
    always_comb begin
        lane_shift = (size_q == 2'b01) ? {addr_lo_q[1], 4'b0000} : {addr_lo_q, 3'b000};
        lane_data  = mem_read_data >> lane_shift;
        case (size_q)
            2'b00:   load_ext = signed_q ? {{24{lane_data[7]}}, lane_data[7:0]}
                                         : {24'h000000, lane_data[7:0]};
            2'b01:   load_ext = signed_q ? {{16{lane_data[15]}}, lane_data[15:0]}
                                         : {16'h0000, lane_data[15:0]};
            default: load_ext = mem_read_data;
        endcase
        lane_mask   = ((size_q == 2'b01) ? 32'h0000FFFF : 32'h000000FF) << lane_shift;
        merged_word = (mem_read_data & ~lane_mask)
                    | (({16'h0000, wdata_q} << lane_shift) & lane_mask);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            we_q           <= 1'b0;
            signed_q       <= 1'b0;
            size_q         <= 2'b00;
            addr_lo_q      <= 2'b00;
            wdata_q        <= 16'h0000;
            req_ready      <= 1'b1;
            resp_valid     <= 1'b0;
            resp_rdata     <= 32'h0;
            resp_fault     <= 1'b0;
            mem_rd         <= 1'b0;
            mem_wn         <= 1'b0;
            mem_address    <= 32'h0;
            mem_write_data <= 32'h0;
        end else begin
            state          <= state_nx;
            if (accept) begin
                we_q      <= req_we;
                signed_q  <= req_signed;
                size_q    <= req_size;
                addr_lo_q <= req_addr[1:0];
                wdata_q   <= req_wdata[15:0];
            end
            req_ready      <= req_ready_d;
            resp_valid     <= resp_valid_d;
            resp_rdata     <= resp_rdata_d;
            resp_fault     <= resp_fault_d;
            mem_rd         <= mem_rd_d;
            mem_wn         <= mem_wn_d;
            mem_address    <= mem_address_d;
            mem_write_data <= mem_write_data_d;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (req_fault)
                        state_nx = S_RESP;
                    else if (req_we && req_size == 2'b10)
                        state_nx = S_WR;
                    else
                        state_nx = S_RD;
                end
            end
            S_RD:    state_nx = S_CAP;
            S_CAP:   state_nx = we_q ? S_WR : S_RESP;
            S_WR:    state_nx = S_RESP;
            S_RESP:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs are registered, so their next values are derived from the next state.
    always_comb begin
        req_ready_d      = (state_nx == S_IDLE);
        resp_valid_d     = (state_nx == S_RESP);
        mem_rd_d         = (state_nx == S_RD);
        mem_wn_d         = (state_nx == S_WR);
        resp_rdata_d     = 32'h0;
        resp_fault_d     = 1'b0;
        mem_address_d    = mem_address;
        mem_write_data_d = mem_write_data;
        if (accept) begin
            resp_fault_d = req_fault;
            if (!req_fault) begin
                mem_address_d = {2'b00, req_addr[31:2]};
                if (req_we && req_size == 2'b10)
                    mem_write_data_d = req_wdata;
            end
        end
        if (state == S_CAP) begin
            if (we_q)
                mem_write_data_d = merged_word;
            else
                resp_rdata_d = load_ext;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 2048-word registered-read memory model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic        mem_rd;
    logic        mem_wn;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    logic [31:0] mem [0:2047];

    int total = 0;
    int bad   = 0;

    int          lat;
    int          rd_cnt;
    int          wn_cnt;
    int          rv_cnt;
    int          rdy_busy;
    logic        rdy_after;
    logic [31:0] r_rdata;
    logic        r_fault;
    logic [31:0] wr_addr;
    int          both_hi = 0;

    mem_access_unit #(.DEPTH_WORDS(2048)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_fault(resp_fault), .mem_rd(mem_rd), .mem_wn(mem_wn),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd && mem_wn) both_hi++;
        if (mem_wn) mem[mem_address[10:0]] <= mem_write_data;
        if (mem_rd) mem_read_data <= mem[mem_address[10:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one request and observes 8 cycles after the acceptance edge.
    task automatic run_req(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata, input bit hold);
        int n;
        bit got;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        if (!hold) req_valid = 1'b0;
        lat = 0; rd_cnt = 0; wn_cnt = 0; rv_cnt = 0; rdy_busy = 0; got = 1'b0;
        rdy_after = 1'b0; r_rdata = 32'hX; r_fault = 1'bX;
        for (int c = 1; c <= 8; c++) begin
            if (mem_rd) rd_cnt++;
            if (mem_wn) begin wn_cnt++; wr_addr = mem_address; end
            if (got && c == lat + 1) begin
                rdy_after = req_ready;
                req_valid = 1'b0;
            end
            if (!got && req_ready) rdy_busy++;
            if (resp_valid) begin
                rv_cnt++;
                if (!got) begin
                    got = 1'b1; lat = c; r_rdata = resp_rdata; r_fault = resp_fault;
                end
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_fault", 32'(resp_fault), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_mem_wn", 32'(mem_wn), 32'd0);
        chk("rst_mem_address", mem_address, 32'h0);
        chk("rst_mem_wdata", mem_write_data, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // word store then load
        run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
        chk("sw_lat", 32'(lat), 32'd2);
        chk("sw_fault", 32'(r_fault), 32'd0);
        chk("sw_rdata", r_rdata, 32'h0);
        chk("sw_wn_cnt", 32'(wn_cnt), 32'd1);
        chk("sw_rd_cnt", 32'(rd_cnt), 32'd0);
        chk("sw_addr", wr_addr, 32'd4);
        chk("sw_mem", mem[4], 32'hDEADBEEF);
        run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
        chk("lw_lat", 32'(lat), 32'd3);
        chk("lw_rdata", r_rdata, 32'hDEADBEEF);
        chk("lw_rd_cnt", 32'(rd_cnt), 32'd1);
        chk("lw_wn_cnt", 32'(wn_cnt), 32'd0);

        // sub-word loads
        mem[8] = 32'h80C1F27F;
        run_req(1'b0, 2'b00, 1'b1, 32'h23, 32'h0, 1'b0);
        chk("lb_23", r_rdata, 32'hFFFFFF80);
        chk("lb_lat", 32'(lat), 32'd3);
        run_req(1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 1'b0);
        chk("lbu_20", r_rdata, 32'h0000007F);
        run_req(1'b0, 2'b00, 1'b0, 32'h22, 32'h0, 1'b0);
        chk("lbu_22", r_rdata, 32'h000000C1);
        run_req(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 1'b0);
        chk("lh_22", r_rdata, 32'hFFFF80C1);
        run_req(1'b0, 2'b01, 1'b0, 32'h20, 32'h0, 1'b0);
        chk("lhu_20", r_rdata, 32'h0000F27F);
        run_req(1'b0, 2'b01, 1'b1, 32'h20, 32'h0, 1'b0);
        chk("lh_20", r_rdata, 32'hFFFFF27F);

        // read-modify-write stores
        mem[12] = 32'h11223344;
        run_req(1'b1, 2'b00, 1'b0, 32'h31, 32'hFFFFFFAB, 1'b0);
        chk("sb_lat", 32'(lat), 32'd4);
        chk("sb_mem", mem[12], 32'h1122AB44);
        chk("sb_rd_cnt", 32'(rd_cnt), 32'd1);
        chk("sb_wn_cnt", 32'(wn_cnt), 32'd1);
        run_req(1'b1, 2'b01, 1'b0, 32'h32, 32'h1234CDEF, 1'b0);
        chk("sh_lat", 32'(lat), 32'd4);
        chk("sh_mem", mem[12], 32'hCDEFAB44);

        // faults
        run_req(1'b0, 2'b10, 1'b0, 32'h02, 32'h0, 1'b0);
        chk("f_lw02_lat", 32'(lat), 32'd1);
        chk("f_lw02_fault", 32'(r_fault), 32'd1);
        chk("f_lw02_rdata", r_rdata, 32'h0);
        chk("f_lw02_acc", 32'(rd_cnt + wn_cnt), 32'd0);
        run_req(1'b1, 2'b01, 1'b0, 32'h05, 32'h5555, 1'b0);
        chk("f_sh05_lat", 32'(lat), 32'd1);
        chk("f_sh05_fault", 32'(r_fault), 32'd1);
        chk("f_sh05_acc", 32'(rd_cnt + wn_cnt), 32'd0);
        run_req(1'b0, 2'b11, 1'b0, 32'h40, 32'h0, 1'b0);
        chk("f_sz11_fault", 32'(r_fault), 32'd1);
        chk("f_sz11_rdata", r_rdata, 32'h0);
        chk("f_sz11_acc", 32'(rd_cnt + wn_cnt), 32'd0);
        run_req(1'b0, 2'b10, 1'b0, 32'h2000, 32'h0, 1'b0);
        chk("f_oor_lat", 32'(lat), 32'd1);
        chk("f_oor_fault", 32'(r_fault), 32'd1);
        chk("f_oor_acc", 32'(rd_cnt + wn_cnt), 32'd0);

        // last valid word
        mem[2047] = 32'hA5A5_0001;
        run_req(1'b0, 2'b10, 1'b0, 32'h1FFC, 32'h0, 1'b0);
        chk("top_fault", 32'(r_fault), 32'd0);
        chk("top_rdata", r_rdata, 32'hA5A50001);

        // handshake: req_valid held through a load
        run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1);
        chk("hold_rdata", r_rdata, 32'hDEADBEEF);
        chk("hold_rd_cnt", 32'(rd_cnt), 32'd1);
        chk("hold_rv_cnt", 32'(rv_cnt), 32'd1);
        chk("hold_busy_ready", 32'(rdy_busy), 32'd0);
        chk("hold_ready_after", 32'(rdy_after), 32'd1);

        // reset during CAP of a byte store
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h31; req_wdata = 32'h55;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_wn", 32'(mem_wn), 32'd0);
        chk("mid_rst_rd", 32'(mem_rd), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd1);
        chk("mid_rst_address", mem_address, 32'h0);
        chk("mid_rst_wdata", mem_write_data, 32'h0);
        rv_cnt = 0; wn_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (c == 1) rst = 1'b0;
            if (mem_wn) wn_cnt++;
            if (resp_valid) rv_cnt++;
        end
        chk("mid_rst_no_wn", 32'(wn_cnt), 32'd0);
        chk("mid_rst_no_resp", 32'(rv_cnt), 32'd0);
        chk("mid_rst_mem", mem[12], 32'hCDEFAB44);
        chk("mid_rst_ready_after", 32'(req_ready), 32'd1);

        run_req(1'b0, 2'b00, 1'b0, 32'h31, 32'h0, 1'b0);
        chk("post_rst_lbu", r_rdata, 32'h000000AB);
        chk("rd_wn_exclusive", 32'(both_hi), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
